// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order commit, CDB capture, mispredict flush.
// Define ROB_LOOKUP_BYPASS_EN to forward same-cycle CDB results to lookups.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int CDB_PORTS = 2,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  input  logic [6:0]                 alloc_opcode,
  input  logic [4:0]                 alloc_rd,
  output logic                       alloc_ready,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [CDB_PORTS-1:0]       cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*32-1:0]    cdb_value,
  input  logic [CDB_PORTS-1:0]       cdb_br_en,
  input  logic [CDB_PORTS*32-1:0]    cdb_br_target,
  input  logic                       commit_ready,
  output logic                       commit_valid,
  output logic [TAG_W-1:0]           commit_tag,
  output logic [6:0]                 commit_opcode,
  output logic [4:0]                 commit_rd,
  output logic [31:0]                commit_value,
  output logic                       flush,
  output logic [31:0]                flush_target,
  input  logic [TAG_W-1:0]           lookup_tag_a,
  input  logic [TAG_W-1:0]           lookup_tag_b,
  output logic                       lookup_ready_a,
  output logic                       lookup_ready_b,
  output logic [31:0]                lookup_value_a,
  output logic [31:0]                lookup_value_b,
  output logic [TAG_W:0]             count,
  output logic                       empty,
  output logic                       full
);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] br_q, br_d;
  logic [6:0]       op_q [DEPTH];
  logic [6:0]       op_d [DEPTH];
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      val_d [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [31:0]      tgt_d [DEPTH];
  logic             alloc_fire;
  logic             commit_fire;
  logic [TAG_W-1:0] ctag;

  assign count         = count_q;
  assign empty         = count_q == '0;
  assign full          = count_q == (TAG_W+1)'(DEPTH);
  assign alloc_tag     = tail_q;
  assign commit_tag    = head_q;
  assign commit_opcode = op_q[head_q];
  assign commit_rd     = rd_q[head_q];
  assign commit_value  = val_q[head_q];
  assign commit_valid  = valid_q[head_q] && done_q[head_q];
  assign commit_fire   = commit_valid && commit_ready;
  assign flush         = commit_fire && br_q[head_q];
  assign flush_target  = tgt_q[head_q];
  assign alloc_ready   = !full && !flush;
  assign alloc_fire    = alloc_valid && alloc_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    br_d    = br_q;
    op_d    = op_q;
    rd_d    = rd_q;
    val_d   = val_q;
    tgt_d   = tgt_q;
    ctag    = '0;
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      br_d[tail_q]    = 1'b0;
      op_d[tail_q]    = alloc_opcode;
      rd_d[tail_q]    = alloc_rd;
      tail_d          = tail_q + 1'b1;
    end
    // Ascending scan: the highest port index writes last and wins.
    for (int i = 0; i < CDB_PORTS; i++) begin
      ctag = cdb_tag[i*TAG_W +: TAG_W];
      if (cdb_valid[i] && valid_q[ctag]) begin
        done_d[ctag] = 1'b1;
        val_d[ctag]  = cdb_value[i*32 +: 32];
        br_d[ctag]   = cdb_br_en[i];
        tgt_d[ctag]  = cdb_br_target[i*32 +: 32];
      end
    end
    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end
    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      br_d    = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      br_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        rd_q[i]  <= '0;
        val_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      br_q    <= br_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
      tgt_q   <= tgt_d;
    end
  end

  logic [TAG_W-1:0] lk_tag [2];
  logic             lk_rdy [2];
  logic [31:0]      lk_val [2];

  assign lk_tag[0] = lookup_tag_a;
  assign lk_tag[1] = lookup_tag_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_rdy[p] = valid_q[lk_tag[p]] && done_q[lk_tag[p]];
      lk_val[p] = valid_q[lk_tag[p]] ? val_q[lk_tag[p]] : '0;
`ifdef ROB_LOOKUP_BYPASS_EN
      for (int i = 0; i < CDB_PORTS; i++) begin
        if (valid_q[lk_tag[p]] && cdb_valid[i] &&
            cdb_tag[i*TAG_W +: TAG_W] == lk_tag[p]) begin
          lk_rdy[p] = 1'b1;
          lk_val[p] = cdb_value[i*32 +: 32];
        end
      end
`endif
    end
  end

  assign lookup_ready_a = lk_rdy[0];
  assign lookup_ready_b = lk_rdy[1];
  assign lookup_value_a = lk_val[0];
  assign lookup_value_b = lk_val[1];

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised circular reorder buffer for the out-of-order RV32I core. It allocates one entry per dispatched instruction and captures results from a configurable number of CDB ports. It retires completed entries in program order through a valid/ready commit port and flushes the whole window when a committed branch resolves as mispredicted. Dispatch and the reservation stations read operand readiness from it through two lookup ports. It sits between dispatch/rename, the CDB, and the architectural regfile/fetch redirect.

## Interface
- DEPTH, 16: number of entries; power of two, at least 2.
- CDB_PORTS, 2: number of parallel CDB writeback channels, at least 1.
- TAG_W, $clog2(DEPTH): derived, not overridable; entry tag width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_opcode  in  7  opcode of the dispatched instruction.
- alloc_rd  in  5  destination register.
- alloc_ready  out  1  allocation is accepted this cycle.
- alloc_tag  out  TAG_W  tag given to the request (the current tail index).
- cdb_valid  in  CDB_PORTS  per-port broadcast valid.
- cdb_tag  in  CDB_PORTS*TAG_W  per-port tag; port i uses bits [i*TAG_W +: TAG_W].
- cdb_value  in  CDB_PORTS*32  per-port result.
- cdb_br_en  in  CDB_PORTS  per-port mispredict/redirect flag.
- cdb_br_target  in  CDB_PORTS*32  per-port redirect target.
- commit_ready  in  1  regfile/LSQ accepts the head entry.
- commit_valid  out  1  head entry is allocated and done.
- commit_tag  out  TAG_W  head tag.
- commit_opcode  out  7  head opcode.
- commit_rd  out  5  head destination register.
- commit_value  out  32  head result.
- flush  out  1  mispredicted branch commits this cycle.
- flush_target  out  32  redirect PC; valid while flush=1.
- lookup_tag_a, lookup_tag_b  in  TAG_W  operand tags to query.
- lookup_ready_a, lookup_ready_b  out  1  queried entry is valid and done.
- lookup_value_a, lookup_value_b  out  32  value of the queried entry.
- count  out  TAG_W+1  number of occupied entries.
- empty, full  out  1  count==0 and count==DEPTH.

## Operation
- State: head and tail pointers of TAG_W bits, a count register, and per entry the fields valid, done, opcode, rd, value, br_en and br_target.
- alloc_ready = !full && !flush. An allocation handshake (alloc_valid && alloc_ready) writes the tail entry with valid=1, done=0 and br_en=0, then advances tail modulo DEPTH.
- CDB capture: for each port with cdb_valid and a target entry with valid=1, set done=1 and write value, br_en and br_target.
  - A broadcast to an invalid entry is ignored.
  - Two ports with the same tag: the higher port index wins.
- Commit: commit_valid = entry[head].valid && entry[head].done. A commit handshake clears the head entry and advances head modulo DEPTH.
- flush = commit handshake && entry[head].br_en, and flush_target = entry[head].br_target.
  - At the next edge, head, tail and count go to 0 and every valid and done bit clears.
  - All other allocations and CDB writes in that cycle are discarded.
- count update: +1 on an allocation only, −1 on a commit only, unchanged when both occur.
- Lookup ports are combinational from entry state. With an invalid entry they return ready=0 and value=0.

## Timing
- Reset (asynchronous, rst_n=0): all entries invalid, head=tail=count=0.
  - Outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, flush=0, empty=1, full=0, count=0, lookup_ready_*=0, lookup_value_*=0, commit_* data=0.
- Reset asserted mid-operation discards all entries immediately.
- A CDB write at edge N makes commit_valid=1 in cycle N+1 when that entry is the head. Allocation-to-commit takes at least 2 cycles.
- An allocation and a commit in the same cycle when full: the allocation is refused (alloc_ready=0), with no same-cycle bypass.
- Allocation and commit together with count=1 is legal; count stays 1.
- Pointer wrap is DEPTH-1 to 0. The full/empty distinction comes from count, not from pointer equality.
- flush is a single-cycle pulse per mispredicted commit.

## Configuration
- ROB_LOOKUP_BYPASS_EN defined: when a lookup tag matches a valid cdb_tag in the same cycle on a valid entry, the lookup port returns ready=1 and that CDB value. The highest matching port wins.
- ROB_LOOKUP_BYPASS_EN undefined: lookups reflect registered entry state only, so a CDB result is visible one cycle later.

## Test plan
- Fill and drain, DEPTH=16, CDB_PORTS=2: 16 allocations give tags 0..15, then alloc_ready=0 and full=1. Write CDB in reverse tag order; commits emerge as tags 0..15 in order, then empty=1.
- Wrap: allocate 10, commit 10, allocate 10. Tags are 10..15, 0..3, and count=10.
- Dual CDB to the same tag 3: port0=0x11 and port1=0x22. The committed value is 0x22.
- Mispredict: tag 2 is written with br_en=1 and target 0x6000_0100 while 5 entries are live. On its commit flush=1 and flush_target=0x6000_0100; the next cycle count=0, and an alloc_valid during the flush cycle is dropped.
- Lookup: tag 4 is written with 0xDEAD_BEEF while lookup_tag_a=4. With ROB_LOOKUP_BYPASS_EN, ready_a=1 in the same cycle; without it, ready_a=1 one cycle later.
- rst_n pulsed low with 7 live entries: outputs return to reset values immediately, and the next allocation gets tag 0.
